// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the two dcaches, the coherence controller and the single RAM port.
// slave = controller side, master = cache/RAM side.
interface coherence_bus_ctrl_if;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping MSI bus controller: arbitration, snoop, cache-to-cache, RAM fill, writeback.
// Define RR_ARB_EN for round-robin tie breaking; default is fixed priority to core 0.
module coherence_bus_ctrl (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  coherence_bus_ctrl_if.slave  cc_bus
);
  // state | meaning
  // IDLE  | arbitrate evictions first, then coherence transactions
  // WB    | write back the requester's block
  // SNOOP | present snoop address/invalidate to the other core
  // C2C   | snooper supplies block to requester and RAM together
  // MEMRD | requester block fill from RAM
  // INV   | upgrade: invalidate snooper copy, no data movement
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WB    = 3'd1;
  localparam logic [2:0] SNOOP = 3'd2;
  localparam logic [2:0] C2C   = 3'd3;
  localparam logic [2:0] MEMRD = 3'd4;
  localparam logic [2:0] INV   = 3'd5;

  localparam logic [1:0] RAM_ACCESS = 2'b10;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_req;
  logic             r_inv;
  logic             r_cnt;
  logic             w_snp;
  logic             w_access;
  logic             w_drop;
  logic [1:0]       w_ev;
  logic             w_ev_pick;
  logic             w_tr_pick;
  logic [1:0]       w_dwait;
  logic [1:0][31:0] w_dload;
  logic [1:0]       w_ccwait;
  logic [1:0]       w_ccinv;
  logic [1:0][31:0] w_snoopaddr;
  logic             w_ren;
  logic             w_wen;
  logic [31:0]      w_ramaddr;
  logic [31:0]      w_ramstore;

  assign w_snp    = ~r_req;
  assign w_access = (cc_bus.ramstate == RAM_ACCESS);
  assign w_ev     = cc_bus.dWEN & ~cc_bus.ccwait & ~cc_bus.cctrans;

`ifdef RR_ARB_EN
  logic r_last;

  function automatic logic f_pick(input logic [1:0] req, input logic last);
    return (&req) ? ~last : ~req[0];
  endfunction

  assign w_ev_pick = f_pick(w_ev, r_last);
  assign w_tr_pick = f_pick(cc_bus.cctrans, r_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE) begin
      if (|w_ev)                r_last <= w_ev_pick;
      else if (|cc_bus.cctrans) r_last <= w_tr_pick;
    end
  end
`else
  assign w_ev_pick = ~w_ev[0];
  assign w_tr_pick = ~cc_bus.cctrans[0];
`endif

  // A requester abandoning its block finishes the word in flight, then releases the bus
  always_comb begin
    w_drop = 1'b0;
    if (r_state == WB) w_drop = ~cc_bus.dWEN[r_req];
    else               w_drop = ~(cc_bus.cctrans[r_req] & cc_bus.dREN[r_req]);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (|w_ev)                w_next = WB;
        else if (|cc_bus.cctrans) w_next = SNOOP;
      end
      SNOOP: begin
        if (r_inv & ~cc_bus.dREN[r_req] & ~cc_bus.dWEN[r_req]) w_next = INV;
        else if (cc_bus.ccwrite[w_snp])                         w_next = C2C;
        else                                                    w_next = MEMRD;
      end
      WB, C2C, MEMRD: if (w_access & (r_cnt | w_drop)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_inv   <= 1'b0;
      r_cnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (|w_ev) begin
          r_req <= w_ev_pick;
        end else if (|cc_bus.cctrans) begin
          r_req <= w_tr_pick;
          r_inv <= cc_bus.ccwrite[w_tr_pick];
        end
      end
      if ((r_state == WB || r_state == C2C || r_state == MEMRD) && w_access)
        r_cnt <= (w_next == IDLE) ? 1'b0 : ~r_cnt;
    end
  end

  always_comb begin
    w_dwait     = 2'b11;
    w_dload     = {cc_bus.ramload, cc_bus.ramload};
    w_ccwait    = 2'b00;
    w_ccinv     = 2'b00;
    w_snoopaddr = '0;
    w_ren       = 1'b0;
    w_wen       = 1'b0;
    w_ramaddr   = '0;
    w_ramstore  = '0;
    case (r_state)
      WB: begin
        w_wen      = 1'b1;
        w_ramaddr  = cc_bus.daddr[r_req];
        w_ramstore = cc_bus.dstore[r_req];
        if (w_access) w_dwait[r_req] = 1'b0;
      end
      SNOOP: begin
        w_ccwait[w_snp]    = 1'b1;
        w_ccinv[w_snp]     = r_inv;
        w_snoopaddr[w_snp] = cc_bus.daddr[r_req];
      end
      C2C: begin
        w_ccwait[w_snp]    = 1'b1;
        w_ccinv[w_snp]     = r_inv;
        w_snoopaddr[w_snp] = cc_bus.daddr[r_req];
        w_wen              = 1'b1;
        w_ramaddr          = cc_bus.daddr[w_snp];
        w_ramstore         = cc_bus.dstore[w_snp];
        w_dload[r_req]     = cc_bus.dstore[w_snp];
        if (w_access) w_dwait = 2'b00;
      end
      MEMRD: begin
        w_ren     = 1'b1;
        w_ramaddr = cc_bus.daddr[r_req];
        if (w_access) w_dwait[r_req] = 1'b0;
      end
      INV: begin
        w_ccwait[w_snp] = 1'b1;
        w_ccinv[w_snp]  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cc_bus.dwait       = w_dwait;
  assign cc_bus.dload       = w_dload;
  assign cc_bus.ccwait      = w_ccwait;
  assign cc_bus.ccinv       = w_ccinv;
  assign cc_bus.ccsnoopaddr = w_snoopaddr;
  assign cc_bus.ramREN      = w_ren;
  assign cc_bus.ramWEN      = w_wen;
  assign cc_bus.ramaddr     = w_ramaddr;
  assign cc_bus.ramstore    = w_ramstore;
endmodule
